addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width; legal values are multiples of 4.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8); IDW = clog2(NUM_REQ).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester accept, at most one bit high.
REQ-007 SHALL have port req_a  input  NUM_REQ*DATA_WIDTH  signed operand A, requester i at slice [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port req_b  input  NUM_REQ*DATA_WIDTH  signed operand B, same packing.
REQ-009 SHALL have port req_sub  input  NUM_REQ  per-requester opcode: 0 = A+B, 1 = A-B.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port rsp_id  output  IDW  index of the requester owning the result.
REQ-013 SHALL have port rsp_result  output  DATA_WIDTH  two's-complement result, wraps modulo 2^DATA_WIDTH.
REQ-014 SHALL have port rsp_overflow  output  1  signed overflow of the requested operation.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL use FSM states IDLE, EXEC, RESP.
REQ-017 Accept SHALL occur in a cycle where req_valid[i] & req_ready[i]; operands, opcode and i are latched; next state EXEC.
REQ-018 req_ready SHALL be the one-hot round-robin grant when state is IDLE, or RESP with rsp_ready=1; otherwise all zero.
REQ-019 Grant SHALL be the first valid requester at or after the priority pointer, searching upward with wrap at NUM_REQ-1 to 0.
REQ-020 On accept of requester i, the pointer SHALL become (i+1) mod NUM_REQ; no accept leaves it unchanged.
REQ-021 EXEC SHALL drive the shared adder with latched A and B (add) or ~B+1 (sub), register result/overflow, go to RESP after one cycle.
REQ-022 Latency SHALL be fixed: accept in cycle T, rsp_valid high from cycle T+2.
REQ-023 In RESP, rsp_valid/rsp_id/rsp_result/rsp_overflow SHALL hold stable while rsp_ready=0.
REQ-024 RESP with rsp_ready=1 SHALL go to EXEC if a request is accepted the same cycle, else to IDLE (back-to-back throughput: one op per 2 cycles).
REQ-025 Add overflow SHALL be (signA==signB) & (signR!=signA); sub overflow SHALL be (signA!=signB) & (signR!=signA), computed from original operands (covers B = most-negative value).
REQ-026 req_valid SHALL be ignored in EXEC and in RESP without rsp_ready; requesters hold until their ready.
REQ-027 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_overflow 0, busy 0, req_ready 0.
REQ-029 Reset mid-operation SHALL discard the in-flight operation with no response issued.
REQ-030 After rst_n rises, the first accept SHALL be possible in the first clock edge with rst_n high.

Structure
REQ-031 Shared package SHALL hold FSM state enum (IDLE/EXEC/RESP) and opcode constants OP_ADD=0, OP_SUB=1.
REQ-032 Block SHALL instantiate exactly one Add_Sub with DATA_WIDTH passed through; its overflow output is used for add only.
REQ-033 Round-robin grant SHALL be one sub-module rr_grant (inputs req, pointer; output one-hot grant).

Verification
REQ-034 Single add: req 0, A=0x0005, B=0x0003, sub=0 -> accept T, rsp_valid T+2, result 0x0008, id 0, overflow 0.
REQ-035 Overflow: A=0x7FFF, B=0x0001 add -> 0x8000, overflow 1; A=0x0000, B=0x8000 sub -> 0x8000, overflow 1; A=0xFFFF, B=0x8000 sub -> 0x7FFF, overflow 0.
REQ-036 Fairness: all 4 valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 with accepts every 2 cycles.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready all 0, no new accept; release -> same-cycle accept of next requester.
REQ-038 Reset in EXEC: rst_n low mid-op -> rsp_valid 0 immediately, no response for that op, pointer 0, first post-reset grant to lowest valid index.

Source files
------------

// File: rtl/addsub_arbiter_pkg.sv
// ============================================================================
// addsub_arbiter_pkg : shared FSM state type and opcode constants
// Revision: 1.0
// ============================================================================
`default_nettype none

package addsub_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/addsub_arbiter_add_sub.sv
// ============================================================================
// Add_Sub : nibble-ripple two's-complement adder with signed overflow flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module Add_Sub #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  overflow
);

    localparam int NIB = DATA_WIDTH / 4;
    localparam int MSB = DATA_WIDTH - 1;

    logic [NIB:0] w_carry;
    logic         w_carry_into_msb;

    assign w_carry[0] = 1'b0;

    generate
        for (genvar k = 0; k < NIB; k++) begin : g_nibble
            assign {w_carry[k+1], sum[k*4 +: 4]} = {1'b0, a[k*4 +: 4]}
                                                 + {1'b0, b[k*4 +: 4]}
                                                 + {4'b0000, w_carry[k]};
        end
    endgenerate

    // Signed overflow: carry into the sign bit differs from carry out of it
    assign w_carry_into_msb = a[MSB] ^ b[MSB] ^ sum[MSB];
    assign overflow         = w_carry_into_msb ^ w_carry[NIB];

endmodule

`default_nettype wire

// File: rtl/addsub_arbiter_rr_grant.sv
// ============================================================================
// rr_grant : one-hot round-robin grant, first request at or above pointer
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     pointer,
    output logic [NUM_REQ-1:0] grant
);

    logic w_found;

    // Walk two laps of indices so the search wraps from NUM_REQ-1 back to 0
    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        for (int k = 0; k < 2 * NUM_REQ; k++) begin
            if (!w_found && (k >= int'(pointer)) && (k < int'(pointer) + NUM_REQ)
                && req[k % NUM_REQ]) begin
                grant[k % NUM_REQ] = 1'b1;
                w_found            = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/addsub_arbiter.sv
// ============================================================================
// addsub_arbiter : round-robin arbiter sharing one add/sub unit among requesters
// Revision: 1.0
// ============================================================================
`default_nettype none

module addsub_arbiter
    import addsub_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REQ    = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b,
    input  logic [NUM_REQ-1:0]              req_sub,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
    output logic [DATA_WIDTH-1:0]           rsp_result,
    output logic                            rsp_overflow,
    output logic                            busy
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int MSB = DATA_WIDTH - 1;

    state_t r_state;
    state_t w_next;

    logic [IDW-1:0]        r_ptr;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_sub;
    logic [IDW-1:0]        r_id;

    logic [NUM_REQ-1:0]    w_grant;
    logic                  w_window;
    logic                  w_accept;
    logic [IDW-1:0]        w_grant_id;
    logic [IDW-1:0]        w_ptr_next;
    logic [DATA_WIDTH-1:0] w_sel_a;
    logic [DATA_WIDTH-1:0] w_sel_b;
    logic                  w_sel_sub;
    logic [DATA_WIDTH-1:0] w_b_eff;
    logic [DATA_WIDTH-1:0] w_sum;
    logic                  w_add_ov;
    logic                  w_sub_ov;
    logic                  w_ov;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_grant (
        .req     (req_valid),
        .pointer (r_ptr),
        .grant   (w_grant)
    );

    assign w_window  = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
    assign req_ready = (w_window && rst_n) ? w_grant : '0;
    assign w_accept  = |(req_ready & req_valid);

    always_comb begin
        w_grant_id = '0;
        w_sel_a    = '0;
        w_sel_b    = '0;
        w_sel_sub  = OP_ADD;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_grant_id = IDW'(i);
                w_sel_a    = req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_b    = req_b[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_sub  = req_sub[i];
            end
        end
    end

    assign w_ptr_next = (w_grant_id == IDW'(NUM_REQ - 1)) ? '0 : w_grant_id + IDW'(1);

    assign w_b_eff = (r_sub == OP_SUB) ? (~r_b + DATA_WIDTH'(1)) : r_b;

    Add_Sub #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_add_sub (
        .a        (r_a),
        .b        (w_b_eff),
        .sum      (w_sum),
        .overflow (w_add_ov)
    );

    // Subtract overflow uses the original B so that B = most-negative is correct
    assign w_sub_ov = (r_a[MSB] != r_b[MSB]) && (w_sum[MSB] != r_a[MSB]);
    assign w_ov     = (r_sub == OP_SUB) ? w_sub_ov : w_add_ov;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = EXEC;
            EXEC:    w_next = RESP;
            RESP:    if (rsp_ready) w_next = w_accept ? EXEC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_sub        <= OP_ADD;
            r_id         <= '0;
            rsp_id       <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= w_sel_a;
                r_b   <= w_sel_b;
                r_sub <= w_sel_sub;
                r_id  <= w_grant_id;
                r_ptr <= w_ptr_next;
            end
            if (r_state == EXEC) begin
                rsp_result   <= w_sum;
                rsp_overflow <= w_ov;
                rsp_id       <= r_id;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
// ============================================================================
// tb_addsub_arbiter : directed self-checking bench for addsub_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_addsub_arbiter;

    localparam int DW = 16;
    localparam int N  = 4;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [DW-1:0]   rsp_result;
    logic            rsp_overflow;
    logic            busy;

    int n_cmp = 0;
    int n_err = 0;

    addsub_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_sub      (req_sub),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic s);
        req_a[id*DW +: DW] = a;
        req_b[id*DW +: DW] = b;
        req_sub[id]        = s;
    endtask

    // One isolated operation from IDLE back to IDLE
    task automatic do_op(input string tag, input int id, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic s,
                         input logic [DW-1:0] exp_res, input logic exp_ov);
        logic [N-1:0] onehot;
        onehot    = 4'b0001 << id;
        set_op(id, a, b, s);
        req_valid = onehot;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(onehot));
        step();
        req_valid = '0;
        chk({tag, "_exec_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_exec_busy"}, 32'(busy), 32'd1);
        step();
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
        chk({tag, "_ovf"}, 32'(rsp_overflow), 32'(exp_ov));
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        step();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int order [5];
        order     = '{0, 1, 2, 3, 0};
        req_valid = 4'b1111;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset state, with all requests asserted
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        step();
        chk("rst_rsp_result", 32'(rsp_result), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
        step();
        req_valid = '0;
        rst_n     = 1'b1;

        // Basic add and the overflow corner cases
        do_op("add_basic", 0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0);
        do_op("add_ovf",   1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        do_op("sub_minneg",2, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1);
        do_op("sub_noovf", 3, 16'hFFFF, 16'h8000, 1'b1, 16'h7FFF, 1'b0);

        // Fairness: all requesters valid, pointer back at 0
        for (int i = 0; i < N; i++) set_op(i, 16'(i * 16), 16'h0001, 1'b0);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("fair_grant", 32'(req_ready), 32'(4'b0001 << order[k]));
            step();
            if (k == 4) req_valid = '0;
            chk("fair_exec_ready", 32'(req_ready), 32'd0);
            chk("fair_exec_valid", 32'(rsp_valid), 32'd0);
            step();
            chk("fair_valid", 32'(rsp_valid), 32'd1);
            chk("fair_id", 32'(rsp_id), 32'(order[k]));
            chk("fair_result", 32'(rsp_result), 32'(order[k] * 16 + 1));
        end
        step();
        chk("fair_idle", 32'(busy), 32'd0);

        // Backpressure: pointer now 1, requesters 1 and 2 waiting
        set_op(1, 16'h1234, 16'h0034, 1'b1);
        set_op(2, 16'h8000, 16'h0001, 1'b1);
        req_valid = 4'b0110;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = 4'b0100;
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_result", 32'(rsp_result), 32'h1200);
            chk("bp_id", 32'(rsp_id), 32'd1);
            chk("bp_ovf", 32'(rsp_overflow), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("bp_release_exec", 32'(rsp_valid), 32'd0);
        step();
        chk("bp2_id", 32'(rsp_id), 32'd2);
        chk("bp2_result", 32'(rsp_result), 32'h7FFF);
        chk("bp2_ovf", 32'(rsp_overflow), 32'd1);
        step();
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset during EXEC: pointer at 3, op discarded
        set_op(3, 16'h0010, 16'h0020, 1'b0);
        req_valid = 4'b1000;
        #1;
        chk("rx_grant", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        chk("rx_exec_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rx_valid_now", 32'(rsp_valid), 32'd0);
        chk("rx_busy_now", 32'(busy), 32'd0);
        step();
        chk("rx_no_rsp1", 32'(rsp_valid), 32'd0);
        step();
        chk("rx_no_rsp2", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1010;
        rst_n     = 1'b1;
        #1;
        chk("rx_post_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("rx_post_exec", 32'(rsp_valid), 32'd0);
        step();
        chk("rx_post_valid", 32'(rsp_valid), 32'd1);
        chk("rx_post_id", 32'(rsp_id), 32'd1);
        chk("rx_post_result", 32'(rsp_result), 32'h1200);
        step();
        chk("rx_post_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
